// File: rtl/sdram_arb_pkg.sv
// Shared types for the three-port SDRAM arbiter: FSM states, port count and port index.
package sdram_arb_pkg;

    localparam int unsigned NPORTS = 3;

    typedef logic [1:0] port_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the three requester ports and the SDRAM controller command/response signals.
interface sdram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 16
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              p0_req,  p1_req,  p2_req;
    logic              p0_we,   p1_we,   p2_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr, p2_addr;
    logic [DATA_W-1:0] p0_din,  p1_din,  p2_din;
    logic [BE_W-1:0]   p0_be,   p1_be,   p2_be;
    logic              p0_ack,  p1_ack,  p2_ack;
    logic [DATA_W-1:0] p0_dout, p1_dout, p2_dout;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_dout;
    logic              busy;

    // Arbiter side
    modport slave (
        input  p0_req, p1_req, p2_req, p0_we, p1_we, p2_we,
        input  p0_addr, p1_addr, p2_addr, p0_din, p1_din, p2_din,
        input  p0_be, p1_be, p2_be, mem_ready, mem_dout,
        output p0_ack, p1_ack, p2_ack, p0_dout, p1_dout, p2_dout,
        output mem_req, mem_we, mem_addr, mem_din, mem_be, busy
    );

    // Requesters plus controller side
    modport master (
        output p0_req, p1_req, p2_req, p0_we, p1_we, p2_we,
        output p0_addr, p1_addr, p2_addr, p0_din, p1_din, p2_din,
        output p0_be, p1_be, p2_be, mem_ready, mem_dout,
        input  p0_ack, p1_ack, p2_ack, p0_dout, p1_dout, p2_dout,
        input  mem_req, mem_we, mem_addr, mem_din, mem_be, busy
    );

endinterface

// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter in front of a single-outstanding SDRAM controller.
// Port 0 has absolute priority; ports 1 and 2 alternate via a round-robin pointer.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 16
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    sdram_port_arbiter_if.slave  bus
);
    localparam int unsigned BE_W = DATA_W / 8;

    state_t                        r_state, w_state_nxt;
    port_idx_t                     r_win, w_win;
    logic                          r_rr_p2;
    logic                          r_mem_req, r_mem_we, r_busy;
    logic [ADDR_W-1:0]             r_mem_addr;
    logic [DATA_W-1:0]             r_mem_din;
    logic [BE_W-1:0]               r_mem_be;
    logic [NPORTS-1:0]             r_ack;
    logic [NPORTS-1:0][DATA_W-1:0] r_dout;

    logic                          w_grant, w_rd_cap, w_mem_req_nxt, w_busy_nxt;
    logic [NPORTS-1:0]             w_ack_nxt;
    logic [NPORTS-1:0]             w_req, w_we;
    logic [NPORTS-1:0][ADDR_W-1:0] w_addr;
    logic [NPORTS-1:0][DATA_W-1:0] w_din;
    logic [NPORTS-1:0][BE_W-1:0]   w_be;

    assign w_req  = {bus.p2_req,  bus.p1_req,  bus.p0_req};
    assign w_we   = {bus.p2_we,   bus.p1_we,   bus.p0_we};
    assign w_addr = {bus.p2_addr, bus.p1_addr, bus.p0_addr};
    assign w_din  = {bus.p2_din,  bus.p1_din,  bus.p0_din};
    assign w_be   = {bus.p2_be,   bus.p1_be,   bus.p0_be};

    // Port 0 always wins; on a 1-vs-2 tie the pointer picks the port not served last
    function automatic port_idx_t pick_winner(input logic [NPORTS-1:0] req, input logic rr_p2);
        port_idx_t win;
        win = 2'd0;
        if (req[0])                 win = 2'd0;
        else if (req[1] && req[2])  win = rr_p2 ? 2'd2 : 2'd1;
        else if (req[1])            win = 2'd1;
        else if (req[2])            win = 2'd2;
        return win;
    endfunction

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (|w_req) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (bus.mem_ready) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are computed one cycle early so they can be registered
    always_comb begin
        w_grant       = 1'b0;
        w_win         = pick_winner(w_req, r_rr_p2);
        w_rd_cap      = 1'b0;
        w_mem_req_nxt = (w_state_nxt == ISSUE);
        w_busy_nxt    = (w_state_nxt != IDLE);
        w_ack_nxt     = '0;
        if (r_state == IDLE && (|w_req))
            w_grant = 1'b1;
        if (r_state == WAIT && bus.mem_ready && !r_mem_we)
            w_rd_cap = 1'b1;
        if (w_state_nxt == DONE)
            w_ack_nxt = NPORTS'(1) << r_win;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_win      <= 2'd0;
            r_rr_p2    <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_be   <= '0;
            r_busy     <= 1'b0;
            r_ack      <= '0;
            r_dout     <= '0;
        end else begin
            r_mem_req <= w_mem_req_nxt;
            r_busy    <= w_busy_nxt;
            r_ack     <= w_ack_nxt;
            if (w_grant) begin
                r_win      <= w_win;
                r_mem_we   <= w_we[w_win];
                r_mem_addr <= w_addr[w_win];
                r_mem_din  <= w_din[w_win];
                r_mem_be   <= w_be[w_win];
                if (w_win == 2'd1)      r_rr_p2 <= 1'b1;
                else if (w_win == 2'd2) r_rr_p2 <= 1'b0;
            end
            if (w_rd_cap)
                r_dout[r_win] <= bus.mem_dout;
        end
    end

    assign bus.mem_req  = r_mem_req;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
    assign bus.mem_be   = r_mem_be;
    assign bus.busy     = r_busy;
    assign bus.p0_ack   = r_ack[0];
    assign bus.p1_ack   = r_ack[1];
    assign bus.p2_ack   = r_ack[2];
    assign bus.p0_dout  = r_dout[0];
    assign bus.p1_dout  = r_dout[1];
    assign bus.p2_dout  = r_dout[2];

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: plays requesters and a simple SDRAM controller.
module tb_sdram_port_arbiter;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    logic [23:0] cap_addr;
    logic        cap_we;
    logic [15:0] cap_din;
    logic [1:0]  cap_be;
    logic [2:0]  cap_acks;

    always #5 clk_sys = ~clk_sys;

    sdram_port_arbiter_if #(.ADDR_W(24), .DATA_W(16)) bus ();

    sdram_port_arbiter #(.ADDR_W(24), .DATA_W(16)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_mem_req(output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clk_sys);
            n++;
            if (bus.mem_req) break;
        end
    endtask

    // Controller model: accept one command, answer lat cycles after mem_req, capture the ack cycle
    task automatic serve(input int lat, input logic [15:0] rd, input logic [2:0] drop, input int exp_wait);
        int n;
        wait_mem_req(n);
        if (!bus.mem_req) begin
            chk("mem_req_timeout", 32'(bus.mem_req), 32'd1);
            cap_acks = 3'b000;
            return;
        end
        if (exp_wait > 0) chk("req_to_mem_req_latency", 32'(n), 32'(exp_wait));
        cap_addr = bus.mem_addr;
        cap_we   = bus.mem_we;
        cap_din  = bus.mem_din;
        cap_be   = bus.mem_be;
        if (drop[0]) bus.p0_req = 1'b0;
        if (drop[1]) bus.p1_req = 1'b0;
        if (drop[2]) bus.p2_req = 1'b0;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk_sys);
            if (i == 0) begin
                chk("mem_req_single_cycle", 32'(bus.mem_req), 32'd0);
                chk("busy_in_wait", 32'(bus.busy), 32'd1);
            end
        end
        chk("no_ack_before_ready", 32'({bus.p2_ack, bus.p1_ack, bus.p0_ack}), 32'd0);
        bus.mem_ready = 1'b1;
        bus.mem_dout  = rd;
        @(negedge clk_sys);
        bus.mem_ready = 1'b0;
        cap_acks = {bus.p2_ack, bus.p1_ack, bus.p0_ack};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.p0_req = 1'b0; bus.p1_req = 1'b0; bus.p2_req = 1'b0;
        bus.p0_we  = 1'b0; bus.p1_we  = 1'b0; bus.p2_we  = 1'b0;
        bus.p0_addr = 24'h000300; bus.p1_addr = 24'h000100; bus.p2_addr = 24'h000200;
        bus.p0_din = '0; bus.p1_din = '0; bus.p2_din = '0;
        bus.p0_be = 2'b11; bus.p1_be = 2'b11; bus.p2_be = 2'b11;
        bus.mem_ready = 1'b0;
        bus.mem_dout  = '0;

        // Reset values
        repeat (2) @(negedge clk_sys);
        chk("rst_busy",     32'(bus.busy), 32'd0);
        chk("rst_mem_req",  32'(bus.mem_req), 32'd0);
        chk("rst_mem_we",   32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_din",  32'(bus.mem_din), 32'd0);
        chk("rst_mem_be",   32'(bus.mem_be), 32'd0);
        chk("rst_acks",     32'({bus.p2_ack, bus.p1_ack, bus.p0_ack}), 32'd0);
        chk("rst_p0_dout",  32'(bus.p0_dout), 32'd0);
        chk("rst_p1_dout",  32'(bus.p1_dout), 32'd0);
        chk("rst_p2_dout",  32'(bus.p2_dout), 32'd0);
        reset = 1'b0;

        // Stray mem_ready in IDLE
        @(negedge clk_sys);
        bus.mem_ready = 1'b1;
        bus.mem_dout  = 16'hAAAA;
        @(negedge clk_sys);
        bus.mem_ready = 1'b0;
        chk("stray_busy",  32'(bus.busy), 32'd0);
        chk("stray_acks",  32'({bus.p2_ack, bus.p1_ack, bus.p0_ack}), 32'd0);
        @(negedge clk_sys);
        chk("stray_busy2",   32'(bus.busy), 32'd0);
        chk("stray_mem_req", 32'(bus.mem_req), 32'd0);
        chk("stray_acks2",   32'({bus.p2_ack, bus.p1_ack, bus.p0_ack}), 32'd0);
        chk("stray_p1_dout", 32'(bus.p1_dout), 32'd0);

        // Contention between ports 1 and 2: 1,2,1,2
        bus.p1_req = 1'b1;
        bus.p2_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(1, 16'(16'h1000 + i), 3'b000, (i == 0) ? 1 : 0);
            chk("rr_addr", 32'(cap_addr), (i % 2 == 0) ? 32'h100 : 32'h200);
            chk("rr_ack",  32'(cap_acks), (i % 2 == 0) ? 32'd2 : 32'd4);
            if (i % 2 == 0) chk("rr_p1_dout", 32'(bus.p1_dout), 32'(16'h1000 + i));
            else            chk("rr_p2_dout", 32'(bus.p2_dout), 32'(16'h1000 + i));
        end
        bus.p1_req = 1'b0;
        bus.p2_req = 1'b0;

        // Priority: p0 first, pointer untouched so p1 next, then p2
        @(negedge clk_sys);
        bus.p0_req = 1'b1; bus.p1_req = 1'b1; bus.p2_req = 1'b1;
        serve(2, 16'h0A0A, 3'b000, 1);
        chk("pri_addr0", 32'(cap_addr), 32'h300);
        chk("pri_ack0",  32'(cap_acks), 32'd1);
        chk("pri_p0_dout", 32'(bus.p0_dout), 32'h0A0A);
        bus.p0_req = 1'b0;
        serve(1, 16'h1111, 3'b000, 0);
        chk("pri_addr1", 32'(cap_addr), 32'h100);
        chk("pri_ack1",  32'(cap_acks), 32'd2);
        chk("pri_p1_dout", 32'(bus.p1_dout), 32'h1111);
        bus.p1_req = 1'b0;
        serve(1, 16'h2222, 3'b000, 0);
        chk("pri_addr2", 32'(cap_addr), 32'h200);
        chk("pri_ack2",  32'(cap_acks), 32'd4);
        chk("pri_p2_dout", 32'(bus.p2_dout), 32'h2222);
        bus.p2_req = 1'b0;

        // Late drop of a port-2 write during ISSUE
        @(negedge clk_sys);
        bus.p2_we = 1'b1; bus.p2_addr = 24'h00FF00; bus.p2_din = 16'h1234; bus.p2_be = 2'b01;
        bus.p2_req = 1'b1;
        serve(2, 16'hDEAD, 3'b100, 1);
        chk("drop_addr", 32'(cap_addr), 32'h00FF00);
        chk("drop_we",   32'(cap_we), 32'd1);
        chk("drop_din",  32'(cap_din), 32'h1234);
        chk("drop_be",   32'(cap_be), 32'd1);
        chk("drop_ack",  32'(cap_acks), 32'd4);
        chk("drop_p2_dout", 32'(bus.p2_dout), 32'h2222);
        bus.p2_we = 1'b0; bus.p2_addr = 24'h000200; bus.p2_be = 2'b11;

        // Single read on port 1, ready 3 cycles after mem_req
        @(negedge clk_sys);
        bus.p1_addr = 24'h000123;
        bus.p1_req  = 1'b1;
        serve(3, 16'hBEEF, 3'b000, 1);
        chk("rd_addr", 32'(cap_addr), 32'h000123);
        chk("rd_we",   32'(cap_we), 32'd0);
        chk("rd_ack",  32'(cap_acks), 32'd2);
        chk("rd_p1_dout", 32'(bus.p1_dout), 32'hBEEF);
        bus.p1_req = 1'b0;
        @(negedge clk_sys);
        chk("rd_ack_one_cycle", 32'({bus.p2_ack, bus.p1_ack, bus.p0_ack}), 32'd0);
        chk("rd_busy_idle",     32'(bus.busy), 32'd0);
        chk("rd_p1_dout_hold",  32'(bus.p1_dout), 32'hBEEF);
        bus.p1_addr = 24'h000100;

        // Reset mid-WAIT (pointer currently favours p2)
        bus.p0_req = 1'b1;
        wait_mem_req(n);
        chk("rstw_mem_req", 32'(bus.mem_req), 32'd1);
        bus.p0_req = 1'b0;
        @(negedge clk_sys);
        chk("rstw_busy_wait", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("rstw_busy",    32'(bus.busy), 32'd0);
        chk("rstw_mem_req0", 32'(bus.mem_req), 32'd0);
        chk("rstw_p0_dout", 32'(bus.p0_dout), 32'd0);
        chk("rstw_p1_dout", 32'(bus.p1_dout), 32'd0);
        reset = 1'b0;
        @(negedge clk_sys);
        bus.mem_ready = 1'b1;
        bus.mem_dout  = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            bus.mem_ready = 1'b0;
            chk("rstw_no_ack", 32'({bus.p2_ack, bus.p1_ack, bus.p0_ack}), 32'd0);
            chk("rstw_idle",   32'(bus.busy), 32'd0);
        end
        bus.p1_req = 1'b1;
        bus.p2_req = 1'b1;
        serve(1, 16'h7777, 3'b000, 1);
        chk("rstw_first_addr", 32'(cap_addr), 32'h100);
        chk("rstw_first_ack",  32'(cap_acks), 32'd2);
        bus.p1_req = 1'b0;
        bus.p2_req = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("end_busy", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
